// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scanner: FSM states, special key codes and
// the key-location / code conversion helpers.
package keypad_pkg;

  typedef enum logic [1:0] {
    StScan,
    StDebounce,
    StPressed,
    StRelease
  } state_e;

  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;

  // Rows 0..2 hold digits 1..9 left to right; row 3 is '*', '0', '#'.
  function automatic logic [3:0] key_map(logic [1:0] r, logic [1:0] c);
    logic [3:0] code;
    if (r == 2'd3) begin
      unique case (c)
        2'd0:    code = KEY_STAR;
        2'd1:    code = 4'd0;
        default: code = KEY_HASH;
      endcase
    end else begin
      code = {2'b00, r} * 4'd3 + {2'b00, c} + 4'd1;
    end
    return code;
  endfunction

  // Digits map to one bit of the 10-bit vector; '*' and '#' map to nothing.
  function automatic logic [9:0] code_onehot(logic [3:0] code);
    logic [9:0] vec;
    vec = '0;
    if (code < 4'd10) vec = 10'd1 << code;
    return vec;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs.
// Ports: clk (clock), rst (synchronous active-low reset), d (async input),
//        q (synchronized output, RESET_VAL after reset).
module sync_2ff #(
  parameter int unsigned     WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta_q <= RESET_VAL;
      q      <= RESET_VAL;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner with press/release debouncing.
// Drives one active-low column per SCAN_DIV-cycle slot, samples the
// synchronized rows at the last cycle of each slot and presents a held,
// glitch-free key level plus a one-cycle key_valid pulse per accepted press.
// Ports: clk, rst (synchronous active-low), row (async active-low rows),
//        col (active-low column drive), keypad (one-hot digit), key_star,
//        key_hash, key_code (last accepted key), key_valid (accept pulse).
// Optional auto-repeat: define KEYPAD_REPEAT_EN (adds REPEAT_DELAY and
// REPEAT_PERIOD; REPEAT_DELAY must be >= REPEAT_PERIOD >= 2).
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 4,
  parameter int unsigned DEBOUNCE_CNT = 8
`ifdef KEYPAD_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY  = 500,
  parameter int unsigned REPEAT_PERIOD = 200
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [2:0] col,
  output logic [9:0] keypad,
  output logic       key_star,
  output logic       key_hash,
  output logic [3:0] key_code,
  output logic       key_valid
);

  localparam int unsigned        SlotW  = $clog2(SCAN_DIV);
  localparam logic [SlotW-1:0]   SlotLast = SlotW'(SCAN_DIV - 1);
  localparam logic [7:0]         DebCnt = 8'(DEBOUNCE_CNT);

  logic [3:0]       row_s;
  logic [SlotW-1:0] slot_q;
  state_e           state_q;
  logic [7:0]       cnt_q;
  logic [7:0]       cnt_inc;
  logic [1:0]       cap_row_q;
  logic [1:0]       low_idx;
  logic [1:0]       col_idx;
  logic             sample;
  logic             single_low;
  logic             all_high;
  logic [3:0]       new_code;

  sync_2ff #(
    .WIDTH    (4),
    .RESET_VAL(4'hF)
  ) u_row_sync (
    .clk(clk),
    .rst(rst),
    .d  (row),
    .q  (row_s)
  );

  assign sample     = (slot_q == SlotLast);
  assign single_low = ($countones(~row_s) == 1);
  assign all_high   = &row_s;
  assign cnt_inc    = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
  assign new_code   = key_map(low_idx, col_idx);

  always_comb begin
    low_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!row_s[i]) low_idx = 2'(i);
    end
  end

  always_comb begin
    if (!col[0])      col_idx = 2'd0;
    else if (!col[1]) col_idx = 2'd1;
    else              col_idx = 2'd2;
  end

`ifdef KEYPAD_REPEAT_EN
  localparam logic [15:0] RptDelay  = 16'(REPEAT_DELAY);
  localparam logic [15:0] RptPeriod = 16'(REPEAT_PERIOD);
  logic [15:0] rpt_cnt_q;
  logic        gap_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      slot_q    <= '0;
      state_q   <= StScan;
      cnt_q     <= '0;
      cap_row_q <= '0;
      col       <= 3'b110;
      keypad    <= '0;
      key_star  <= 1'b0;
      key_hash  <= 1'b0;
      key_code  <= '0;
      key_valid <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rpt_cnt_q <= '0;
      gap_q     <= 1'b0;
`endif
    end else begin
      key_valid <= 1'b0;
      slot_q    <= (slot_q == SlotLast) ? '0 : slot_q + 1'b1;

`ifdef KEYPAD_REPEAT_EN
      // Repeat counter only runs while PRESSED; a gap drops the active output
      // for one cycle, and its re-rise is reported as a new press.
      if (state_q == StPressed) begin
        if (gap_q) begin
          gap_q     <= 1'b0;
          keypad    <= code_onehot(key_code);
          key_star  <= (key_code == KEY_STAR);
          key_hash  <= (key_code == KEY_HASH);
          key_valid <= 1'b1;
        end
        if (rpt_cnt_q == RptDelay - 16'd1) begin
          gap_q     <= 1'b1;
          keypad    <= '0;
          key_star  <= 1'b0;
          key_hash  <= 1'b0;
          rpt_cnt_q <= RptDelay - RptPeriod;
        end else begin
          rpt_cnt_q <= rpt_cnt_q + 16'd1;
        end
      end else begin
        // A gap that straddles entry to RELEASE must not leave the key low.
        if (gap_q && state_q == StRelease) begin
          keypad   <= code_onehot(key_code);
          key_star <= (key_code == KEY_STAR);
          key_hash <= (key_code == KEY_HASH);
        end
        rpt_cnt_q <= '0;
        gap_q     <= 1'b0;
      end
`endif

      if (sample) begin
        unique case (state_q)
          StScan: begin
            if (single_low) begin
              cap_row_q <= low_idx;
              if (DebCnt <= 8'd1) begin
                state_q   <= StPressed;
                cnt_q     <= '0;
                key_code  <= new_code;
                keypad    <= code_onehot(new_code);
                key_star  <= (new_code == KEY_STAR);
                key_hash  <= (new_code == KEY_HASH);
                key_valid <= 1'b1;
              end else begin
                state_q <= StDebounce;
                cnt_q   <= 8'd1;
              end
            end else begin
              col <= {col[1:0], col[2]};
            end
          end
          StDebounce: begin
            if (single_low && low_idx == cap_row_q) begin
              if (cnt_inc >= DebCnt) begin
                state_q   <= StPressed;
                cnt_q     <= '0;
                key_code  <= new_code;
                keypad    <= code_onehot(new_code);
                key_star  <= (new_code == KEY_STAR);
                key_hash  <= (new_code == KEY_HASH);
                key_valid <= 1'b1;
              end else begin
                cnt_q <= cnt_inc;
              end
            end else begin
              state_q <= StScan;
              cnt_q   <= '0;
              col     <= {col[1:0], col[2]};
            end
          end
          StPressed: begin
            // Rollover patterns are ignored; only all-high starts a release.
            if (all_high) begin
              if (DebCnt <= 8'd1) begin
                state_q  <= StScan;
                cnt_q    <= '0;
                keypad   <= '0;
                key_star <= 1'b0;
                key_hash <= 1'b0;
                col      <= {col[1:0], col[2]};
              end else begin
                state_q <= StRelease;
                cnt_q   <= 8'd1;
              end
            end
          end
          StRelease: begin
            if (all_high) begin
              if (cnt_inc >= DebCnt) begin
                state_q  <= StScan;
                cnt_q    <= '0;
                keypad   <= '0;
                key_star <= 1'b0;
                key_hash <= 1'b0;
                col      <= {col[1:0], col[2]};
              end else begin
                cnt_q <= cnt_inc;
              end
            end else begin
              state_q <= StPressed;
              cnt_q   <= '0;
            end
          end
          default: state_q <= StScan;
        endcase
      end
    end
  end

endmodule
